// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU and multdiv results onto the single regfile write port.
// Optional stall-cycle counter enabled by defining WB_STATS_EN.
module wb_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             md_valid,
  input  logic [4:0]       md_rd,
  input  logic [31:0]      md_data,
  output logic             md_ready,
  output logic             stall,
  output logic [31:0]      DATA_WR,
  output logic [31:0]      EN
`ifdef WB_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic          fifo_vld  [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;

  logic        alu_wr, fifo_empty, md_xfer, md_kill, pop, bypass, push;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  assign md_ready   = (count != FULL);
  assign stall      = (count == FULL);
  assign fifo_empty = (count == '0);
  assign md_xfer    = md_valid & md_ready;
  assign alu_wr     = alu_valid & (alu_rd != 5'd0);
  // A same-cycle multdiv result to the ALU's rd is older; the ALU value wins.
  assign md_kill    = alu_wr & (md_rd == alu_rd);
  // Any ALU result, even to r0, owns the port and blocks the pop.
  assign pop        = ~alu_valid & ~fifo_empty;
  assign bypass     = ~alu_wr & fifo_empty & md_xfer & (md_rd != 5'd0);
  assign push       = md_xfer & ~bypass & ~md_kill & (md_rd != 5'd0);

  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    if (alu_wr) begin
      wr_en   = 1'b1;
      wr_rd   = alu_rd;
      wr_data = alu_data;
    end else if (pop) begin
      wr_en   = fifo_vld[head] & (fifo_rd[head] != 5'd0);
      wr_rd   = fifo_rd[head];
      wr_data = fifo_data[head];
    end else if (bypass) begin
      wr_en   = 1'b1;
      wr_rd   = md_rd;
      wr_data = md_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      EN      <= '0;
      DATA_WR <= '0;
    end else begin
      EN <= wr_en ? (32'd1 << wr_rd) : 32'd0;
      if (wr_en) DATA_WR <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd[i]   <= '0;
        fifo_data[i] <= '0;
        fifo_vld[i]  <= 1'b0;
      end
    end else begin
      // Stale entries keep their slot but must not overwrite the newer ALU value.
      for (int i = 0; i < DEPTH; i++)
        if (alu_wr && fifo_rd[i] == alu_rd) fifo_vld[i] <= 1'b0;
      if (push) begin
        fifo_rd[tail]   <= md_rd;
        fifo_data[tail] <= md_data;
        fifo_vld[tail]  <= 1'b1;
        tail            <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                        stall_cnt <= '0;
    else if (stall && ~&stall_cnt)   stall_cnt <= stall_cnt + 1'b1;
  end
`else
  logic [CNT_W-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter; stall counter checks compile in with WB_STATS_EN.
module tb_wb_write_arbiter;
  logic        clk = 1'b0;
  logic        clr;
  logic        alu_valid, md_valid;
  logic [4:0]  alu_rd, md_rd;
  logic [31:0] alu_data, md_data;
  logic        md_ready, stall;
  logic [31:0] DATA_WR, EN;
`ifdef WB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .clr(clr),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
    .md_ready(md_ready), .stall(stall),
    .DATA_WR(DATA_WR), .EN(EN)
`ifdef WB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic md(input logic v, input logic [4:0] rd, input logic [31:0] d);
    md_valid = v; md_rd = rd; md_data = d;
  endtask

  initial begin
    clr = 1'b0;
    alu(0, 0, 0);
    md(0, 0, 0);
    @(negedge clk);
    chk("rst_en", EN, 0);
    chk("rst_data", DATA_WR, 0);
    chk("rst_ready", {31'd0, md_ready}, 1);
    chk("rst_stall", {31'd0, stall}, 0);
`ifdef WB_STATS_EN
    chk("rst_cnt", {16'd0, stall_cnt}, 0);
`endif
    clr = 1'b1;
    cyc();

    // ALU only
    alu(1, 5, 32'hDEADBEEF);
    cyc();
    chk("alu_en", EN, 32'h20);
    chk("alu_data", DATA_WR, 32'hDEADBEEF);
    alu(0, 0, 0);
    cyc();
    chk("alu_en_off", EN, 0);
    chk("alu_hold", DATA_WR, 32'hDEADBEEF);

    // r0 drops
    alu(1, 0, 32'h55);
    cyc();
    chk("r0_alu_en", EN, 0);
    alu(0, 0, 0);
    md(1, 0, 32'h66);
    chk("r0_md_ready", {31'd0, md_ready}, 1);
    cyc();
    md(0, 0, 0);
    chk("r0_md_en", EN, 0);
    chk("r0_md_ready2", {31'd0, md_ready}, 1);
    cyc();
    chk("r0_md_en2", EN, 0);
    chk("r0_hold", DATA_WR, 32'hDEADBEEF);

    // Conflict buffering
    alu(1, 1, 32'h100); md(1, 10, 1);
    cyc();
    chk("cf_en1", EN, 32'h2);
    chk("cf_ready1", {31'd0, md_ready}, 1);
    alu(1, 2, 32'h200); md(1, 11, 2);
    cyc();
    chk("cf_en2", EN, 32'h4);
    chk("cf_ready2", {31'd0, md_ready}, 0);
    chk("cf_stall2", {31'd0, stall}, 1);
    alu(1, 3, 32'h300); md(1, 12, 3);
    cyc();
    chk("cf_en3", EN, 32'h8);
    chk("cf_stall3", {31'd0, stall}, 1);
    alu(0, 0, 0);
    cyc();
    chk("cf_pop10_en", EN, 32'h400);
    chk("cf_pop10_d", DATA_WR, 1);
    chk("cf_ready4", {31'd0, md_ready}, 1);
    cyc();
    md(0, 0, 0);
    chk("cf_pop11_en", EN, 32'h800);
    chk("cf_pop11_d", DATA_WR, 2);
    cyc();
    chk("cf_pop12_en", EN, 32'h1000);
    chk("cf_pop12_d", DATA_WR, 3);
    cyc();
    chk("cf_idle_en", EN, 0);
    chk("cf_idle_stall", {31'd0, stall}, 0);

    // WAW kill
    alu(1, 1, 32'hAAAA); md(1, 7, 32'h1111);
    cyc();
    chk("waw_en1", EN, 32'h2);
    alu(1, 7, 32'h2222); md(0, 0, 0);
    cyc();
    chk("waw_en7", EN, 32'h80);
    chk("waw_d7", DATA_WR, 32'h2222);
    alu(0, 0, 0);
    cyc();
    chk("waw_pop_en", EN, 0);
    chk("waw_pop_d", DATA_WR, 32'h2222);
    md(1, 4, 32'h44);
    cyc();
    md(0, 0, 0);
    chk("waw_bypass_en", EN, 32'h10);
    chk("waw_bypass_d", DATA_WR, 32'h44);

    // Same-cycle same-rd
    alu(1, 9, 32'hA); md(1, 9, 32'hB);
    cyc();
    alu(0, 0, 0); md(0, 0, 0);
    chk("same_en", EN, 32'h200);
    chk("same_d", DATA_WR, 32'hA);
    cyc();
    chk("same_en2", EN, 0);
    chk("same_d2", DATA_WR, 32'hA);
    chk("same_ready", {31'd0, md_ready}, 1);

    // Async reset mid-drain
    alu(1, 1, 32'h1); md(1, 20, 32'h14);
    cyc();
    alu(1, 2, 32'h2); md(1, 21, 32'h15);
    cyc();
    alu(0, 0, 0); md(0, 0, 0);
    chk("ar_stall", {31'd0, stall}, 1);
    chk("ar_en_pre", EN, 32'h4);
    #1 clr = 1'b0;
    #1;
    chk("ar_en", EN, 0);
    chk("ar_data", DATA_WR, 0);
    chk("ar_ready", {31'd0, md_ready}, 1);
    chk("ar_stall0", {31'd0, stall}, 0);
    #1 clr = 1'b1;
    cyc();
    chk("ar_post_en1", EN, 0);
    cyc();
    chk("ar_post_en2", EN, 0);
    chk("ar_post_ready", {31'd0, md_ready}, 1);

`ifdef WB_STATS_EN
    chk("st_cnt0", {16'd0, stall_cnt}, 0);
    alu(1, 1, 32'h1); md(1, 20, 32'h14);
    cyc();
    alu(1, 2, 32'h2); md(1, 21, 32'h15);
    cyc();
    md(0, 0, 0);
    alu(1, 3, 32'h3);
    chk("st_full", {31'd0, stall}, 1);
    chk("st_cnt_start", {16'd0, stall_cnt}, 0);
    repeat (3) cyc();
    chk("st_cnt3", {16'd0, stall_cnt}, 3);
    repeat (65600) @(posedge clk);
    @(negedge clk);
    chk("st_cnt_sat", {16'd0, stall_cnt}, 32'hFFFF);
    alu(0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
